// File: rtl/datapath_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : datapath_ctrl_if
// Description : Bundle of handshake and datapath-control signals between the
//               instruction controller and its surroundings.
//               master = controller side, slave = instruction source/datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface datapath_ctrl_if;
   logic        s;
   logic [15:0] instr;
   logic        w;
   logic        err_illegal;
   logic        halted;
   logic [15:0] datapath_in;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic        loadc;
   logic        loads;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  shift;
   logic [1:0]  ALUop;

   modport master (
      input  s, instr,
      output w, err_illegal, halted, datapath_in,
      output write, vsel, loada, loadb, asel, bsel, loadc, loads,
      output readnum, writenum, shift, ALUop
   );

   modport slave (
      output s, instr,
      input  w, err_illegal, halted, datapath_in,
      input  write, vsel, loada, loadb, asel, bsel, loadc, loads,
      input  readnum, writenum, shift, ALUop
   );
endinterface
`default_nettype wire

// File: rtl/datapath_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : datapath_ctrl
// Description : Moore FSM sequencing a register-file/ALU datapath, one 16-bit
//               instruction at a time (MOV imm, MOV reg, ADD, CMP, AND, MVN).
//               Optional macro DATAPATH_CTRL_HALT_EN: opcode 111 enters a
//               HALT state left only by reset; without it opcode 111 is
//               illegal and halted is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_ctrl #(
   parameter bit IMM_SIGNED = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   datapath_ctrl_if.master bus
);

   localparam logic [2:0] c_WAIT      = 3'd0;
   localparam logic [2:0] c_DECODE    = 3'd1;
   localparam logic [2:0] c_WRITE_IMM = 3'd2;
   localparam logic [2:0] c_GET_A     = 3'd3;
   localparam logic [2:0] c_GET_B     = 3'd4;
   localparam logic [2:0] c_ALU       = 3'd5;
   localparam logic [2:0] c_WRITE_REG = 3'd6;
`ifdef DATAPATH_CTRL_HALT_EN
   localparam logic [2:0] c_HALT      = 3'd7;
`endif

   logic [2:0]  state_q, state_d;
   logic [15:0] ir_q, ir_d;

   // Instruction fields of the latched IR
   logic [2:0] w_opcode, w_rn, w_rd, w_rm;
   logic [1:0] w_op, w_sh;
   logic       w_mov_imm, w_mov_reg, w_add, w_cmp, w_and, w_mvn, w_halt_op;

   assign w_opcode  = ir_q[15:13];
   assign w_op      = ir_q[12:11];
   assign w_rn      = ir_q[10:8];
   assign w_rd      = ir_q[7:5];
   assign w_sh      = ir_q[4:3];
   assign w_rm      = ir_q[2:0];

   assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
   assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
   assign w_add     = (w_opcode == 3'b101) && (w_op == 2'b00);
   assign w_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);
   assign w_and     = (w_opcode == 3'b101) && (w_op == 2'b10);
   assign w_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
`ifdef DATAPATH_CTRL_HALT_EN
   assign w_halt_op = (w_opcode == 3'b111);
`else
   assign w_halt_op = 1'b0;
`endif

   // Immediate extension depends only on the IR, so it is valid in every state
   assign bus.datapath_in = IMM_SIGNED ? {{8{ir_q[7]}}, ir_q[7:0]} : {8'h00, ir_q[7:0]};
   // No instruction ever routes the B operand past the shifter's bypass
   assign bus.bsel        = 1'b0;

   // Next-state, IR capture and per-state control outputs (Moore)
   always_comb begin
      state_d         = state_q;
      ir_d            = ir_q;
      bus.w           = 1'b0;
      bus.err_illegal = 1'b0;
      bus.halted      = 1'b0;
      bus.write       = 1'b0;
      bus.vsel        = 1'b0;
      bus.loada       = 1'b0;
      bus.loadb       = 1'b0;
      bus.asel        = 1'b0;
      bus.loadc       = 1'b0;
      bus.loads       = 1'b0;
      bus.readnum     = 3'd0;
      bus.writenum    = 3'd0;
      bus.shift       = 2'b00;
      bus.ALUop       = 2'b00;
      case (state_q)
         c_WAIT: begin
            bus.w = 1'b1;
            if (bus.s) begin
               ir_d    = bus.instr;
               state_d = c_DECODE;
            end
         end
         c_DECODE: begin
            if (w_mov_imm)                   state_d = c_WRITE_IMM;
            else if (w_mov_reg || w_mvn)     state_d = c_GET_B;
            else if (w_add || w_cmp || w_and) state_d = c_GET_A;
`ifdef DATAPATH_CTRL_HALT_EN
            else if (w_halt_op)              state_d = c_HALT;
`endif
            else begin
               bus.err_illegal = 1'b1;
               state_d         = c_WAIT;
            end
         end
         c_WRITE_IMM: begin
            bus.vsel     = 1'b1;
            bus.write    = 1'b1;
            bus.writenum = w_rn;
            state_d      = c_WAIT;
         end
         c_GET_A: begin
            bus.readnum = w_rn;
            bus.loada   = 1'b1;
            state_d     = c_GET_B;
         end
         c_GET_B: begin
            bus.readnum = w_rm;
            bus.loadb   = 1'b1;
            state_d     = c_ALU;
         end
         c_ALU: begin
            bus.shift = w_sh;
            // MOV/MVN ignore the A operand by forcing it to zero
            bus.asel  = w_mov_reg || w_mvn;
            if (w_mvn)      bus.ALUop = 2'b11;
            else if (w_and) bus.ALUop = 2'b10;
            else if (w_cmp) bus.ALUop = 2'b01;
            else            bus.ALUop = 2'b00;
            if (w_cmp) begin
               bus.loads = 1'b1;
               state_d   = c_WAIT;
            end else begin
               bus.loadc = 1'b1;
               state_d   = c_WRITE_REG;
            end
         end
         c_WRITE_REG: begin
            bus.write    = 1'b1;
            bus.writenum = w_rd;
            state_d      = c_WAIT;
         end
`ifdef DATAPATH_CTRL_HALT_EN
         c_HALT: begin
            bus.halted = 1'b1;
            state_d    = c_HALT;
         end
`endif
         default: state_d = c_WAIT;
      endcase
   end

   // State and instruction register, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= c_WAIT;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

endmodule
`default_nettype wire
